// File: rtl/mult_div_pkg.sv
// Shared encodings for the multicycle multiply/divide unit.
package mult_div_pkg;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_FIX  = 2'b10,
      ST_DONE = 2'b11
   } state_t;

   function automatic logic is_div(input logic [1:0] op);
      return op[1];
   endfunction

   function automatic logic is_signed_op(input logic [1:0] op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/md_step.sv
// One iteration of the shared datapath: shift-add for multiply, restoring shift-subtract for divide.
module md_step
   import mult_div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [1:0]         mode,
   input  logic [2*WIDTH-1:0] part,
   input  logic [WIDTH-1:0]   operand,
   output logic [2*WIDTH-1:0] next_part,
   output logic               q_bit
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] trial;
   logic [WIDTH:0] diff;

   always_comb begin
      sum       = {1'b0, part[2*WIDTH-1:WIDTH]} + {1'b0, operand};
      trial     = {part[2*WIDTH-1:WIDTH], part[WIDTH-1]};
      diff      = trial - {1'b0, operand};
      q_bit     = 1'b0;
      next_part = part;
      if (is_div(mode)) begin
         // diff[WIDTH] is the borrow: set exactly when the trial subtraction goes negative
         q_bit = ~diff[WIDTH];
         if (q_bit)
            next_part = {diff[WIDTH-1:0], part[WIDTH-2:0], 1'b0};
         else
            next_part = {trial[WIDTH-1:0], part[WIDTH-2:0], 1'b0};
      end else if (part[0]) begin
         next_part = {sum, part[WIDTH-1:1]};
      end else begin
         next_part = {1'b0, part[2*WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/mult_div_n.sv
// Multicycle signed/unsigned multiply/divide unit owning the HI/LO result registers.
module mult_div_n
   import mult_div_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   state_t               state;
   logic [1:0]           op_r;
   logic [2*WIDTH-1:0]   acc;
   logic [WIDTH-1:0]     mag_b;
   logic                 neg_lo;
   logic                 neg_hi;
   logic [CNT_W-1:0]     cnt;
   logic [2*WIDTH-1:0]   step_part;
   logic                 q_bit;
   logic                 sgn_a;
   logic                 sgn_b;

   function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
      return neg ? (~v + 1'b1) : v;
   endfunction

   function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic neg);
      return neg ? (~v + 1'b1) : v;
   endfunction

   assign sgn_a = is_signed_op(op) & a[WIDTH-1];
   assign sgn_b = is_signed_op(op) & b[WIDTH-1];

   md_step #(.WIDTH(WIDTH)) u_step (
      .mode      (op_r),
      .part      (acc),
      .operand   (mag_b),
      .next_part (step_part),
      .q_bit     (q_bit)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         op_r     <= OP_MULT;
         acc      <= '0;
         mag_b    <= '0;
         neg_lo   <= 1'b0;
         neg_hi   <= 1'b0;
         cnt      <= '0;
         hi       <= '0;
         lo       <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  op_r <= op;
                  if (is_div(op) && (b == '0)) begin
                     state    <= ST_DONE;
                     done     <= 1'b1;
                     div_zero <= 1'b1;
                  end else begin
                     state  <= ST_RUN;
                     cnt    <= CNT_W'(WIDTH);
                     acc    <= {{WIDTH{1'b0}}, cond_neg(a, sgn_a)};
                     mag_b  <= cond_neg(b, sgn_b);
                     neg_lo <= sgn_a ^ sgn_b;
                     // remainder follows the dividend; a product negates as a whole
                     neg_hi <= is_div(op) ? sgn_a : (sgn_a ^ sgn_b);
                  end
               end
            end
            ST_RUN: begin
               acc <= {step_part[2*WIDTH-1:1], step_part[0] | q_bit};
               cnt <= cnt - 1'b1;
               if (cnt == CNT_W'(1))
                  state <= ST_FIX;
            end
            ST_FIX: begin
               if (is_div(op_r)) begin
                  lo <= cond_neg(acc[WIDTH-1:0], neg_lo);
                  hi <= cond_neg(acc[2*WIDTH-1:WIDTH], neg_hi);
               end else begin
                  {hi, lo} <= cond_neg2(acc, neg_lo);
               end
               state    <= ST_DONE;
               done     <= 1'b1;
               div_zero <= 1'b0;
            end
            ST_DONE: begin
               state    <= ST_IDLE;
               busy     <= 1'b0;
               done     <= 1'b0;
               div_zero <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_n.sv
// Directed bench for mult_div_n: arithmetic model with per-cycle compare plus literal checks.
module tb_mult_div_n;

   localparam int W = 32;

   logic          clk   = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [1:0]    op    = 2'b00;
   logic [W-1:0]  a     = '0;
   logic [W-1:0]  b     = '0;
   logic          busy, done, div_zero;
   logic [W-1:0]  hi, lo;

   logic          start8 = 1'b0;
   logic [1:0]    op8    = 2'b00;
   logic [7:0]    a8     = '0;
   logic [7:0]    b8     = '0;
   logic          busy8, done8, dz8;
   logic [7:0]    hi8, lo8;

   int vectors     = 0;
   int miscompares = 0;
   bit check_en    = 1'b0;

   always #5 clk = ~clk;

   mult_div_n #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
   );

   mult_div_n #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: exact arithmetic results, released after a fixed latency
   function automatic void model_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] rh, output logic [31:0] rl, output logic z);
      longint     sx, sy, q, r;
      logic [63:0] p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      z  = 1'b0;
      p  = '0;
      case (o)
         2'b00: p = sx * sy;
         2'b01: p = {32'b0, x} * {32'b0, y};
         2'b10: begin
            if (y == 0) z = 1'b1;
            else begin
               q = sx / sy;
               r = sx % sy;
               p = {r[31:0], q[31:0]};
            end
         end
         default: begin
            if (y == 0) z = 1'b1;
            else p = {x % y, x / y};
         end
      endcase
      rh = p[63:32];
      rl = p[31:0];
   endfunction

   logic          m_busy, m_done, m_dz;
   logic [W-1:0]  m_hi, m_lo, p_hi, p_lo;
   int            m_left;

   always @(posedge clk or negedge reset) begin
      logic [31:0] th, tl;
      logic        tz;
      if (!reset) begin
         m_busy <= 1'b0; m_done <= 1'b0; m_dz <= 1'b0;
         m_hi   <= '0;   m_lo   <= '0;   m_left <= 0;
      end else if (m_done) begin
         m_done <= 1'b0; m_dz <= 1'b0; m_busy <= 1'b0;
      end else if (m_busy) begin
         m_left <= m_left - 1;
         if (m_left == 1) begin
            m_done <= 1'b1;
            m_hi   <= p_hi;
            m_lo   <= p_lo;
         end
      end else if (start) begin
         model_op(op, a, b, th, tl, tz);
         m_busy <= 1'b1;
         if (tz) begin
            m_done <= 1'b1;
            m_dz   <= 1'b1;
         end else begin
            p_hi   <= th;
            p_lo   <= tl;
            m_left <= W + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         chk("busy", busy, m_busy);
         chk("done", done, m_done);
         chk("div_zero", div_zero, m_dz);
         chk("hi", hi, m_hi);
         chk("lo", lo, m_lo);
      end
   end

   task automatic do_op(input string nm, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eh, input logic [31:0] el, input logic ez, input int lat,
                        input bit restart);
      int n;
      @(negedge clk);
      op = o; a = x; b = y; start = 1'b1;
      @(negedge clk);
      start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
      n = 0;
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
         start = (restart && n == 5);
      end
      start = 1'b0;
      chk({nm, "_latency"}, 64'(n), 64'(lat));
      chk({nm, "_hi"}, hi, eh);
      chk({nm, "_lo"}, lo, el);
      chk({nm, "_dz"}, div_zero, ez);
      chk({nm, "_model_hi"}, m_hi, eh);
      chk({nm, "_model_lo"}, m_lo, el);
      @(negedge clk);
   endtask

   initial begin
      int n;
      #1 reset = 1'b0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_dz", div_zero, 0);
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      check_en = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b1;

      do_op("mult_neg",  2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33, 1'b0);
      do_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33, 1'b0);
      do_op("mult_m1",   2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 33, 1'b0);
      do_op("div_neg",   2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, 1'b0);
      do_op("divu",      2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 33, 1'b0);
      do_op("divu_zero", 2'b11, 32'd100,      32'd0,        32'd2,        32'd14,       1'b1, 0,  1'b0);
      do_op("div_ovf",   2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33, 1'b1);

      // async reset in the middle of a run
      @(negedge clk);
      op = 2'b01; a = 32'd5; b = 32'd9; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_hi", hi, 0);
      chk("midrst_lo", lo, 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // narrow instance: most-negative squared
      op8 = 2'b00; a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      chk("w8_busy", busy8, 1);
      n = 0;
      while (!done8 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("w8_latency", 64'(n), 64'd9);
      chk("w8_hi", hi8, 8'h40);
      chk("w8_lo", lo8, 8'h00);
      chk("w8_dz", dz8, 0);
      @(negedge clk);
      chk("w8_idle", busy8, 0);

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
